// File: rtl/evg_event_arbiter.sv
// Event-code arbiter for the EVG 16-bit transmit word: per-source pending latches, K28.5 comma
// insertion and distributed-bus merge. Define EVG_ARB_ROUND_ROBIN_EN for round-robin service of sources 1..N-1.
module evg_event_arbiter #(
    parameter int REQUESTER_COUNT       = 4,
    parameter int COMMA_INTERVAL        = 1024,
    parameter int DISTRIBUTED_BUS_WIDTH = 8
) (
    input  logic                             evgTxClk,
    input  logic                             evgRst_n,
    input  logic [REQUESTER_COUNT-1:0]       evgRequest,
    input  logic [8*REQUESTER_COUNT-1:0]     evgEventCodes,
    input  logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus,
    input  logic                             evgOverflowClear,
    output logic [15:0]                      evgTxData,
    output logic [1:0]                       evgTxCharIsK,
    output logic [REQUESTER_COUNT-1:0]       evgGrant,
    output logic [REQUESTER_COUNT-1:0]       evgPending,
    output logic [REQUESTER_COUNT-1:0]       evgOverflow
);
    localparam int              CW           = $clog2(COMMA_INTERVAL);
    localparam logic [CW-1:0]   COMMA_RELOAD = CW'(COMMA_INTERVAL - 1);
    localparam logic [7:0]      K28_5        = 8'hBC;

    logic [CW-1:0]              commaCount;
    logic                       commaSlot;
    logic [7:0]                 codeLatch [REQUESTER_COUNT];
    logic [REQUESTER_COUNT-1:0] validReq;
    logic [REQUESTER_COUNT-1:0] candidates;
    logic [REQUESTER_COUNT-1:0] winner;
    logic [7:0]                 winnerCode;
    logic [7:0]                 busByte;
    logic                       found;

    assign commaSlot = (commaCount == '0);

    // A strobe carrying the null code is treated as no request at all.
    always_comb begin
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            validReq[i] = evgRequest[i] && (evgEventCodes[8*i +: 8] != 8'h00);
        end
        candidates = evgPending | validReq;
    end

    always_comb begin
        busByte = '0;
        busByte[DISTRIBUTED_BUS_WIDTH-1:0] = evgDistributedBus;
    end

`ifdef EVG_ARB_ROUND_ROBIN_EN
    localparam int IW = (REQUESTER_COUNT > 2) ? $clog2(REQUESTER_COUNT) : 1;

    logic [IW-1:0] rrPointer;
    logic [IW-1:0] nextPointer;
    logic [IW-1:0] rrIndex;
    int            idxInt;

    // NOTE: combinational blocks assign every variable first, so no latch can be inferred.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idxInt  = 0;
        rrIndex = '0;
        if (!commaSlot) begin
            if (candidates[0]) begin
                winner[0] = 1'b1;
            end else begin
                for (int k = 0; k < REQUESTER_COUNT - 1; k++) begin
                    idxInt = int'(rrPointer) + k;
                    if (idxInt >= REQUESTER_COUNT) idxInt = idxInt - (REQUESTER_COUNT - 1);
                    rrIndex = IW'(idxInt);
                    if (!found && candidates[rrIndex]) begin
                        winner[rrIndex] = 1'b1;
                        found           = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        nextPointer = rrPointer;
        for (int i = 1; i < REQUESTER_COUNT; i++) begin
            if (winner[i]) nextPointer = (i == REQUESTER_COUNT - 1) ? IW'(1) : IW'(i + 1);
        end
    end

    always_ff @(posedge evgTxClk or negedge evgRst_n) begin
        if (!evgRst_n) begin
            rrPointer <= IW'(1);
        end else if (|winner[REQUESTER_COUNT-1:1]) begin
            rrPointer <= nextPointer;
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (!commaSlot) begin
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                if (!found && candidates[i]) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end
`endif

    // A pending source emits its latched (older) code; otherwise the strobe's code goes straight out.
    always_comb begin
        winnerCode = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (winner[i]) begin
                winnerCode = winnerCode | (evgPending[i] ? codeLatch[i] : evgEventCodes[8*i +: 8]);
            end
        end
    end

    // NOTE: code latches are only ever read under evgPending, so they carry no reset.
    always_ff @(posedge evgTxClk) begin
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (validReq[i] && (!evgPending[i] || winner[i])) codeLatch[i] <= evgEventCodes[8*i +: 8];
        end
    end

    always_ff @(posedge evgTxClk or negedge evgRst_n) begin
        if (!evgRst_n) begin
            commaCount   <= COMMA_RELOAD;
            evgTxData    <= '0;
            evgTxCharIsK <= '0;
            evgGrant     <= '0;
            evgPending   <= '0;
            evgOverflow  <= '0;
        end else begin
            commaCount   <= commaSlot ? COMMA_RELOAD : commaCount - CW'(1);
            evgTxData    <= {busByte, commaSlot ? K28_5 : winnerCode};
            evgTxCharIsK <= {1'b0, commaSlot};
            evgGrant     <= winner;
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                if (winner[i]) begin
                    evgPending[i] <= evgPending[i] && validReq[i];
                end else if (validReq[i]) begin
                    evgPending[i] <= 1'b1;
                end
                // A new loss on this cycle outranks the clear.
                evgOverflow[i] <= (validReq[i] && evgPending[i] && !winner[i])
                               || (evgOverflow[i] && !evgOverflowClear);
            end
        end
    end
endmodule

// File: tb/tb_evg_event_arbiter.sv
// Scoreboard bench for evg_event_arbiter: a cycle model pushes expected words as stimulus is driven,
// the DUT output is popped and compared one cycle later; scenario tasks add directed checks.
module tb_evg_event_arbiter;
    localparam int N  = 4;
    localparam int CI = 1024;

    logic           evgTxClk = 1'b0;
    logic           evgRst_n = 1'b0;
    logic [N-1:0]   evgRequest = '0;
    logic [8*N-1:0] evgEventCodes = '0;
    logic [7:0]     evgDistributedBus = '0;
    logic           evgOverflowClear = 1'b0;
    logic [15:0]    evgTxData;
    logic [1:0]     evgTxCharIsK;
    logic [N-1:0]   evgGrant;
    logic [N-1:0]   evgPending;
    logic [N-1:0]   evgOverflow;

    evg_event_arbiter #(
        .REQUESTER_COUNT(N),
        .COMMA_INTERVAL(CI),
        .DISTRIBUTED_BUS_WIDTH(8)
    ) dut (
        .evgTxClk(evgTxClk),
        .evgRst_n(evgRst_n),
        .evgRequest(evgRequest),
        .evgEventCodes(evgEventCodes),
        .evgDistributedBus(evgDistributedBus),
        .evgOverflowClear(evgOverflowClear),
        .evgTxData(evgTxData),
        .evgTxCharIsK(evgTxCharIsK),
        .evgGrant(evgGrant),
        .evgPending(evgPending),
        .evgOverflow(evgOverflow)
    );

    always #5 evgTxClk = ~evgTxClk;

    typedef struct {
        logic [15:0]  data;
        logic [1:0]   k;
        logic [N-1:0] grant;
        logic [N-1:0] pending;
        logic [N-1:0] overflow;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [N-1:0] mPend;
    logic [N-1:0] mOv;
    logic [7:0]   mCode [N];
    int           mCnt;
    int           mPtr;

    task automatic model_reset();
        mPend = '0;
        mOv   = '0;
        mCnt  = CI - 1;
        mPtr  = 1;
        expQ.delete();
    endtask

    task automatic model_push(input logic [N-1:0] req, input logic [8*N-1:0] codes,
                              input logic clr, input logic [7:0] bus);
        exp_t         e;
        logic [N-1:0] v;
        logic [N-1:0] cand;
        int           w;
        int           idx;
        for (int i = 0; i < N; i++) v[i] = req[i] && (codes[8*i +: 8] != 8'h00);
        e.data  = {bus, 8'h00};
        e.k     = 2'b00;
        e.grant = '0;
        w       = -1;
        if (clr) mOv = '0;
        if (mCnt == 0) begin
            e.data[7:0] = 8'hBC;
            e.k         = 2'b01;
            mCnt        = CI - 1;
        end else begin
            mCnt = mCnt - 1;
            cand = mPend | v;
`ifdef EVG_ARB_ROUND_ROBIN_EN
            if (cand[0]) w = 0;
            else begin
                for (int k = 0; k < N - 1; k++) begin
                    idx = ((mPtr - 1 + k) % (N - 1)) + 1;
                    if (w < 0 && cand[idx]) w = idx;
                end
                if (w > 0) mPtr = (w % (N - 1)) + 1;
            end
`else
            for (int i = 0; i < N; i++) if (w < 0 && cand[i]) w = i;
`endif
            if (w >= 0) begin
                e.grant[w]  = 1'b1;
                e.data[7:0] = mPend[w] ? mCode[w] : codes[8*w +: 8];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == w) begin
                if (mPend[i] && v[i]) mCode[i] = codes[8*i +: 8];
                else mPend[i] = 1'b0;
            end else if (v[i]) begin
                if (mPend[i]) mOv[i] = 1'b1;
                else begin
                    mPend[i] = 1'b1;
                    mCode[i] = codes[8*i +: 8];
                end
            end
        end
        e.pending  = mPend;
        e.overflow = mOv;
        expQ.push_back(e);
    endtask

    task automatic scoreboard_pop();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: DUT word with no expected entry");
            return;
        end
        e = expQ.pop_front();
        if (evgTxData !== e.data) begin
            failures++;
            $display("FAIL sb_data: got %h expected %h", evgTxData, e.data);
        end
        checks++;
        if (evgTxCharIsK !== e.k) begin
            failures++;
            $display("FAIL sb_k: got %b expected %b", evgTxCharIsK, e.k);
        end
        checks++;
        if (evgGrant !== e.grant) begin
            failures++;
            $display("FAIL sb_grant: got %b expected %b", evgGrant, e.grant);
        end
        checks++;
        if (evgPending !== e.pending) begin
            failures++;
            $display("FAIL sb_pending: got %b expected %b", evgPending, e.pending);
        end
        checks++;
        if (evgOverflow !== e.overflow) begin
            failures++;
            $display("FAIL sb_overflow: got %b expected %b", evgOverflow, e.overflow);
        end
    endtask

    // One transmit cycle: drive, model, clock, then compare away from the edge.
    task automatic step(input logic [N-1:0] req, input logic [8*N-1:0] codes, input logic clr);
        logic [7:0] bus;
        bus               = 8'($urandom);
        evgRequest        = req;
        evgEventCodes     = codes;
        evgDistributedBus = bus;
        evgOverflowClear  = clr;
        model_push(req, codes, clr, bus);
        @(posedge evgTxClk);
        #1;
        evgRequest       = '0;
        evgOverflowClear = 1'b0;
        scoreboard_pop();
    endtask

    task automatic do_reset();
        evgRst_n   = 1'b0;
        evgRequest = '0;
        @(posedge evgTxClk);
        #1;
        model_reset();
        evgRst_n = 1'b1;
    endtask

    task automatic test_reset();
        int firstComma  = -1;
        int secondComma = -1;
        int bcCount     = 0;
        evgRst_n = 1'b0;
        @(posedge evgTxClk);
        #1;
        checks++;
        if ({evgTxData, evgTxCharIsK, evgGrant, evgPending, evgOverflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h k=%b grant=%b pend=%b ovf=%b expected all zero",
                     evgTxData, evgTxCharIsK, evgGrant, evgPending, evgOverflow);
        end
        model_reset();
        evgRst_n = 1'b1;
        for (int c = 1; c <= 2 * CI; c++) begin
            step('0, '0, 1'b0);
            if (evgTxData[7:0] == 8'hBC) begin
                bcCount++;
                if (firstComma < 0) firstComma = c;
                else if (secondComma < 0) secondComma = c;
            end
        end
        checks++;
        if (firstComma !== CI) begin
            failures++;
            $display("FAIL first_comma: got cycle %0d expected %0d", firstComma, CI);
        end
        checks++;
        if (secondComma !== 2 * CI) begin
            failures++;
            $display("FAIL second_comma: got cycle %0d expected %0d", secondComma, 2 * CI);
        end
        checks++;
        if (bcCount !== 2) begin
            failures++;
            $display("FAIL comma_count: got %0d expected 2", bcCount);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0]   expD [4] = '{8'h70, 8'h71, 8'h72, 8'h73};
        logic [N-1:0] expG [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [N-1:0] expP [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            step((s == 0) ? 4'hF : 4'h0, 32'h73727170, 1'b0);
            checks++;
            if (evgTxData[7:0] !== expD[s] || evgGrant !== expG[s] || evgPending !== expP[s]) begin
                failures++;
                $display("FAIL simultaneous[%0d]: got code=%h grant=%b pend=%b expected code=%h grant=%b pend=%b",
                         s, evgTxData[7:0], evgGrant, evgPending, expD[s], expG[s], expP[s]);
            end
        end
    endtask

    task automatic test_comma_collision();
        int guard = 0;
        while (mCnt != 0 && guard < 2 * CI) begin
            step('0, '0, 1'b0);
            guard++;
        end
        checks++;
        if (mCnt != 0) begin
            failures++;
            $display("FAIL comma_wait: comma slot not reached within %0d cycles", 2 * CI);
        end
        step(4'b0100, 32'h007A0000, 1'b0);
        checks++;
        if (evgTxData[7:0] !== 8'hBC || evgTxCharIsK !== 2'b01 || evgGrant !== 4'b0000 || evgPending !== 4'b0100) begin
            failures++;
            $display("FAIL comma_collision_slot: got code=%h k=%b grant=%b pend=%b expected code=bc k=01 grant=0000 pend=0100",
                     evgTxData[7:0], evgTxCharIsK, evgGrant, evgPending);
        end
        step('0, '0, 1'b0);
        checks++;
        if (evgTxData[7:0] !== 8'h7A || evgTxCharIsK !== 2'b00 || evgGrant !== 4'b0100 || evgOverflow !== 4'b0000) begin
            failures++;
            $display("FAIL comma_collision_next: got code=%h k=%b grant=%b ovf=%b expected code=7a k=00 grant=0100 ovf=0000",
                     evgTxData[7:0], evgTxCharIsK, evgGrant, evgOverflow);
        end
    endtask

    task automatic test_overflow_clear();
        do_reset();
        step(4'b1001, 32'h11000055, 1'b0);
        step(4'b1001, 32'h22000055, 1'b0);
        checks++;
        if (evgOverflow[3] !== 1'b1 || evgPending[3] !== 1'b1 || evgTxData[7:0] !== 8'h55) begin
            failures++;
            $display("FAIL overflow_set: got ovf=%b pend=%b code=%h expected ovf[3]=1 pend[3]=1 code=55",
                     evgOverflow, evgPending, evgTxData[7:0]);
        end
        step(4'b0001, 32'h00000055, 1'b0);
        step('0, '0, 1'b0);
        checks++;
        if (evgTxData[7:0] !== 8'h11 || evgGrant !== 4'b1000 || evgPending !== 4'b0000) begin
            failures++;
            $display("FAIL overflow_kept_code: got code=%h grant=%b pend=%b expected code=11 grant=1000 pend=0000",
                     evgTxData[7:0], evgGrant, evgPending);
        end
        step(4'b1001, 32'h33000055, 1'b0);
        step(4'b1001, 32'h44000055, 1'b1);
        checks++;
        if (evgOverflow !== 4'b1000) begin
            failures++;
            $display("FAIL clear_vs_overflow: got ovf=%b expected 1000", evgOverflow);
        end
        step('0, '0, 1'b1);
        checks++;
        if (evgOverflow !== 4'b0000 || evgTxData[7:0] !== 8'h33) begin
            failures++;
            $display("FAIL clear_alone: got ovf=%b code=%h expected ovf=0000 code=33", evgOverflow, evgTxData[7:0]);
        end
    endtask

    task automatic test_null_code();
        do_reset();
        step(4'b0010, 32'h00000000, 1'b0);
        checks++;
        if (evgPending !== 4'b0000 || evgGrant !== 4'b0000 || evgOverflow !== 4'b0000 || evgTxData[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL null_code: got pend=%b grant=%b ovf=%b code=%h expected all zero",
                     evgPending, evgGrant, evgOverflow, evgTxData[7:0]);
        end
    endtask

    task automatic test_saturation();
`ifdef EVG_ARB_ROUND_ROBIN_EN
        logic [N-1:0] expG [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
`else
        logic [N-1:0] expG [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        do_reset();
        for (int s = 0; s < 6; s++) begin
            step(4'b1110, 32'h33323100, 1'b0);
            checks++;
            if (evgGrant !== expG[s]) begin
                failures++;
                $display("FAIL saturation_grant[%0d]: got %b expected %b", s, evgGrant, expG[s]);
            end
        end
        step(4'b1111, 32'h3332310F, 1'b0);
        checks++;
        if (evgGrant !== 4'b0001 || evgTxData[7:0] !== 8'h0F) begin
            failures++;
            $display("FAIL source0_preempt: got grant=%b code=%h expected grant=0001 code=0f", evgGrant, evgTxData[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b1110, 32'h33323100, 1'b0);
        step(4'b1110, 32'h33323100, 1'b0);
        evgRst_n = 1'b0;
        #2;
        checks++;
        if (evgPending !== 4'b0000 || evgOverflow !== 4'b0000 || evgGrant !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid: got pend=%b ovf=%b grant=%b expected all zero", evgPending, evgOverflow, evgGrant);
        end
        do_reset();
        step('0, '0, 1'b0);
        checks++;
        if (evgPending !== 4'b0000 || evgTxData[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_after: got pend=%b code=%h expected pend=0000 code=00", evgPending, evgTxData[7:0]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   req;
        logic [8*N-1:0] codes;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                codes[8*i +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            end
            step(req & N'($urandom), codes, ($urandom_range(0, 7) == 0));
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d unmatched entries expected 0", expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_comma_collision();
        test_overflow_clear();
        test_null_code();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
